// File: rtl/seg7_pair_decoder_if.sv
// Display-bus loopback link: active-low digit pair in, decoded reading out with valid/ready.
// The master drives the segment patterns and rdy; the slave returns the decoded value and status.
interface seg7_pair_decoder_if #(
    parameter int VALUE_W = 5
);
    logic [6:0]         hex_tens;
    logic [6:0]         hex_ones;
    logic               rdy;
    logic [VALUE_W-1:0] value_dat;
    logic               vld;
    logic               err;
    logic               overrun;

    modport master (
        output hex_tens, hex_ones, rdy,
        input  value_dat, vld, err, overrun
    );

    modport slave (
        input  hex_tens, hex_ones, rdy,
        output value_dat, vld, err, overrun
    );
endinterface

// File: rtl/seg7_pair_decoder.sv
// Debounces and decodes a two-digit active-low 7-seg pair (0..19); latency STABLE_CYCLES+1 edges.
// Each new settled reading is held on vld until rdy; input changes while holding set sticky overrun.
module seg7_pair_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_VALUE     = 19,
    parameter int VALUE_W       = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    seg7_pair_decoder_if.slave io_bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [6:0]       MAX_SUM    = 7'(MAX_VALUE);
    localparam logic [13:0]      BLANK_PAIR = {7'h7F, 7'h7F};

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]         r_state;
    logic [13:0]        r_sample;
    logic [13:0]        r_last_pair;
    logic [CNT_W-1:0]   r_cnt;
    logic [VALUE_W-1:0] r_value;
    logic               r_valid;
    logic               r_error;
    logic               r_overrun;

    logic [13:0] w_pair;
    logic [4:0]  w_tens_dec;
    logic [4:0]  w_ones_dec;
    logic [6:0]  w_sum;
    logic        w_legal;

    // Returns {legal, digit}; only the canonical glyphs are accepted.
    function automatic logic [4:0] f_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = {1'b1, 4'd0};
            7'h79:   res = {1'b1, 4'd1};
            7'h24:   res = {1'b1, 4'd2};
            7'h30:   res = {1'b1, 4'd3};
            7'h19:   res = {1'b1, 4'd4};
            7'h12:   res = {1'b1, 4'd5};
            7'h02:   res = {1'b1, 4'd6};
            7'h78:   res = {1'b1, 4'd7};
            7'h00:   res = {1'b1, 4'd8};
            7'h10:   res = {1'b1, 4'd9};
            default: res = 5'd0;
        endcase
        return res;
    endfunction

    assign w_pair     = {io_bus.hex_tens, io_bus.hex_ones};
    assign w_tens_dec = f_decode(r_sample[13:7]);
    assign w_ones_dec = f_decode(r_sample[6:0]);
    assign w_sum      = ({3'd0, w_tens_dec[3:0]} * 7'd10) + {3'd0, w_ones_dec[3:0]};
    assign w_legal    = w_tens_dec[4] & w_ones_dec[4] & (w_sum <= MAX_SUM);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_WAIT;
            r_sample    <= BLANK_PAIR;
            r_last_pair <= BLANK_PAIR;
            r_cnt       <= '0;
            r_value     <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                ST_WAIT: begin
                    if (w_pair != r_last_pair) begin
                        r_sample <= w_pair;
                        r_cnt    <= CNT_W'(1);
                        r_state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt < STABLE_CNT) begin
                        if (w_pair != r_sample) begin
                            r_sample <= w_pair;
                            r_cnt    <= CNT_W'(1);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_last_pair <= r_sample;
                        // A glitch that settles back onto the last reported pair is not news.
                        if (r_sample == r_last_pair) begin
                            r_state <= ST_WAIT;
                        end else if (w_legal) begin
                            r_value <= VALUE_W'(w_sum);
                            r_valid <= 1'b1;
                            r_state <= ST_HOLD;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_pair != r_last_pair) begin
                        r_overrun <= 1'b1;
                    end
                    if (io_bus.rdy) begin
                        r_valid <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    assign io_bus.value_dat = r_value;
    assign io_bus.vld       = r_valid;
    assign io_bus.err       = r_error;
    assign io_bus.overrun   = r_overrun;
endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Directed bench for seg7_pair_decoder with STABLE_CYCLES=4, MAX_VALUE=19.
module tb_seg7_pair_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rises   = 0;
    int   errs    = 0;
    int   both    = 0;
    int   base_r;
    int   base_e;
    logic prev_v  = 1'b0;
    logic [6:0] pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_pair_decoder_if #(.VALUE_W(5)) bus ();

    seg7_pair_decoder #(.STABLE_CYCLES(4), .MAX_VALUE(19), .VALUE_W(5)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.vld && !prev_v) rises++;
            if (bus.err) errs++;
            if (bus.vld && bus.err) both++;
            prev_v = bus.vld;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic [6:0] t, input logic [6:0] o);
        bus.hex_tens = t;
        bus.hex_ones = o;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ready_pulse();
        bus.rdy = 1'b1;
        tick(1);
        bus.rdy = 1'b0;
    endtask

    initial begin
        set_pair(7'h7F, 7'h7F);
        bus.rdy = 1'b0;

        // 1: reset state, then 12
        #2;
        chk("rst_value", 32'(bus.value_dat), 0);
        chk("rst_valid", 32'(bus.vld), 0);
        chk("rst_error", 32'(bus.err), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        set_pair(7'h79, 7'h24);
        tick(4);
        chk("t1_valid_edge4", 32'(bus.vld), 0);
        tick(1);
        chk("t1_valid_edge5", 32'(bus.vld), 1);
        chk("t1_value", 32'(bus.value_dat), 12);
        ready_pulse();
        chk("t1_valid_after_ready", 32'(bus.vld), 0);

        // 2: bouncing ones digit settles on 3
        base_r = rises;
        bus.hex_tens = 7'h40;
        for (int i = 0; i < 6; i++) begin
            bus.hex_ones = (i % 2 == 1) ? 7'h30 : 7'h24;
            tick(1);
        end
        bus.hex_ones = 7'h30;
        tick(10);
        chk("t2_single_valid", 32'(rises - base_r), 1);
        chk("t2_value", 32'(bus.value_dat), 3);
        ready_pulse();
        base_r = rises;
        set_pair(7'h40, 7'h78);
        tick(3);
        bus.hex_ones = 7'h79;
        tick(10);
        chk("t2_short_hold_rises", 32'(rises - base_r), 1);
        chk("t2_short_hold_value", 32'(bus.value_dat), 1);
        ready_pulse();

        // 3: illegal pairs
        base_r = rises;
        base_e = errs;
        set_pair(7'h24, 7'h40);
        tick(4);
        chk("t3_err_edge4", 32'(bus.err), 0);
        tick(1);
        chk("t3_err_edge5", 32'(bus.err), 1);
        chk("t3_valid_with_err", 32'(bus.vld), 0);
        tick(1);
        chk("t3_err_one_cycle", 32'(bus.err), 0);
        set_pair(7'h40, 7'h7F);
        tick(10);
        set_pair(7'h7F, 7'h40);
        tick(10);
        chk("t3_err_count", 32'(errs - base_e), 3);
        chk("t3_no_valid", 32'(rises - base_r), 0);
        chk("t3_value_kept", 32'(bus.value_dat), 1);

        // 4: overrun while holding 5
        set_pair(7'h40, 7'h12);
        tick(4);
        chk("t4_valid_edge4", 32'(bus.vld), 0);
        tick(1);
        chk("t4_valid", 32'(bus.vld), 1);
        chk("t4_value5", 32'(bus.value_dat), 5);
        bus.hex_ones = 7'h78;
        tick(2);
        chk("t4_overrun", 32'(bus.overrun), 1);
        chk("t4_value_frozen", 32'(bus.value_dat), 5);
        ready_pulse();
        chk("t4_valid_dropped", 32'(bus.vld), 0);
        tick(4);
        chk("t4_valid_edge4b", 32'(bus.vld), 0);
        tick(1);
        chk("t4_revalid", 32'(bus.vld), 1);
        chk("t4_value7", 32'(bus.value_dat), 7);
        chk("t4_overrun_sticky", 32'(bus.overrun), 1);
        ready_pulse();

        // 5: long hold reports once; glitch back to same pair reports nothing
        base_r = rises;
        base_e = errs;
        bus.rdy = 1'b1;
        set_pair(7'h40, 7'h10);
        tick(100);
        chk("t5_one_valid", 32'(rises - base_r), 1);
        chk("t5_value9", 32'(bus.value_dat), 9);
        set_pair(7'h79, 7'h10);
        tick(1);
        set_pair(7'h40, 7'h10);
        tick(20);
        bus.rdy = 1'b0;
        chk("t5_no_rereport", 32'(rises - base_r), 1);
        chk("t5_no_error", 32'(errs - base_e), 0);
        chk("t5_value_still9", 32'(bus.value_dat), 9);

        // 6: async reset mid-SETTLE and mid-HOLD
        set_pair(7'h79, 7'h30);
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6a_valid", 32'(bus.vld), 0);
        chk("t6a_error", 32'(bus.err), 0);
        chk("t6a_overrun", 32'(bus.overrun), 0);
        chk("t6a_value", 32'(bus.value_dat), 0);
        rst = 1'b0;
        set_pair(7'h40, 7'h19);
        tick(6);
        chk("t6b_valid", 32'(bus.vld), 1);
        chk("t6b_value4", 32'(bus.value_dat), 4);
        bus.hex_ones = 7'h02;
        tick(1);
        chk("t6b_overrun", 32'(bus.overrun), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6b_valid_rst", 32'(bus.vld), 0);
        chk("t6b_overrun_rst", 32'(bus.overrun), 0);
        chk("t6b_value_rst", 32'(bus.value_dat), 0);
        rst = 1'b0;
        set_pair(7'h79, 7'h40);
        tick(4);
        chk("t6c_valid_edge4", 32'(bus.vld), 0);
        tick(1);
        chk("t6c_valid", 32'(bus.vld), 1);
        chk("t6c_value10", 32'(bus.value_dat), 10);
        ready_pulse();

        for (int v = 0; v < 20; v++) begin
            set_pair((v >= 10) ? 7'h79 : 7'h40, pats[v % 10]);
            tick(5);
            chk($sformatf("sweep_valid_%0d", v), 32'(bus.vld), 1);
            chk($sformatf("sweep_value_%0d", v), 32'(bus.value_dat), 32'(v));
            ready_pulse();
        end

        chk("valid_error_exclusive", 32'(both), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
